// File: rtl/tone_pkg.sv
// Shared constants and state type for the tone sequencer.
// S_GAP exists only when TONE_SEQ_GAP_EN is defined.
package tone_pkg;

  localparam logic [2:0] NOTE_LAST = 3'd7;

  // Divider half-period counts, Do up to Do2
  localparam logic [15:0] NOTE_TABLE [8] = '{
    16'd47801, 16'd42589, 16'd37936, 16'd35816,
    16'd31928, 16'd28409, 16'd25329, 16'd23901
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY
`ifdef TONE_SEQ_GAP_EN
    , S_GAP
`endif
  } tone_state_t;

endpackage

// File: rtl/tick_gen.sv
// Duration prescaler: tick pulses once every TICK_DIV clocks.
// The count restarts from zero whenever clr is high.
module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (clr || r_cnt == LAST)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/tone_sequencer.sv
// Selects the audio divider half-period: manual switches or scale playback.
// Define TONE_SEQ_GAP_EN to insert silent gaps between scale notes.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int TICK_DIV   = 50000,
  parameter int NOTE_TICKS = 250,
  parameter int GAP_TICKS  = 20,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             manual_en,
  input  logic [2:0]       sw,
  output logic [DIV_W-1:0] half_period,
  output logic             tone_en,
  output logic [2:0]       note_idx,
  output logic             busy,
  output logic             done
);

  localparam int DUR_MAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int DUR_W   = $clog2(DUR_MAX + 1);

  tone_state_t      r_state;
  logic [DUR_W-1:0] r_dur;
  logic             r_man_q;

  logic             w_tick;
  logic             w_clr;
  logic             w_abort;
  logic             w_end;
  logic [DUR_W-1:0] w_lim;
  logic [2:0]       w_next_idx;

  assign w_next_idx = note_idx + 3'd1;

  always_comb begin
    w_lim = DUR_W'(NOTE_TICKS - 1);
`ifdef TONE_SEQ_GAP_EN
    if (r_state == S_GAP)
      w_lim = DUR_W'(GAP_TICKS - 1);
`endif
    w_abort = (r_state != S_IDLE) && manual_en && !r_man_q;
    w_end   = (r_state != S_IDLE) && w_tick && (r_dur == w_lim);
    // Hold the prescaler at zero in IDLE so every duration starts exact
    w_clr   = (r_state == S_IDLE) || w_abort || w_end;
  end

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_dur <= '0;
    else if (w_clr)
      r_dur <= '0;
    else if (w_tick)
      r_dur <= r_dur + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_man_q     <= 1'b0;
      half_period <= DIV_W'(NOTE_TABLE[0]);
      note_idx    <= 3'd0;
      tone_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      r_man_q <= manual_en;
      done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (manual_en) begin
            note_idx    <= sw;
            half_period <= DIV_W'(NOTE_TABLE[sw]);
            tone_en     <= 1'b1;
          end else if (start) begin
            r_state     <= S_PLAY;
            note_idx    <= 3'd0;
            half_period <= DIV_W'(NOTE_TABLE[0]);
            tone_en     <= 1'b1;
            busy        <= 1'b1;
          end else begin
            tone_en     <= 1'b0;
          end
        end
        default: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            tone_en <= 1'b0;
            busy    <= 1'b0;
          end else if (w_end) begin
            if (r_state == S_PLAY) begin
              if (note_idx == NOTE_LAST) begin
                r_state <= S_IDLE;
                tone_en <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
`ifdef TONE_SEQ_GAP_EN
                r_state <= S_GAP;
                tone_en <= 1'b0;
`else
                note_idx    <= w_next_idx;
                half_period <= DIV_W'(NOTE_TABLE[w_next_idx]);
`endif
              end
            end
`ifdef TONE_SEQ_GAP_EN
            else begin
              r_state     <= S_PLAY;
              tone_en     <= 1'b1;
              note_idx    <= w_next_idx;
              half_period <= DIV_W'(NOTE_TABLE[w_next_idx]);
            end
`endif
          end
        end
      endcase
    end
  end

endmodule
